// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: requester encoding,
// the fixed external access type and default widths.
package dm_arb_pkg;

  // Requester identity, also the encoding of last_grant.
  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_EXT = 1'b1
  } req_e;

  // External accesses are always full-word.
  localparam logic [2:0] DMT_WORD = 3'b000;

  localparam int AW_DEF        = 30;
  localparam int DW_DEF        = 32;
  localparam int MAX_BURST_DEF = 8;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the CPU port, the external port and the data-memory port.
// Handshake: a requester raises *_req with its fields and keeps them stable
// until the cycle in which *_gnt is 1; that cycle issues the access. A read
// returns *_rvalid with *_rdata exactly one cycle after its grant; a write
// is acknowledged by the grant alone. Dropping *_req before a grant cancels
// the access. slave = arbiter side, master = requesters plus memory.
interface dm_arb_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0]    cpu_dmtype;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_lock;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;

  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din;
  logic [2:0]    dm_dmtype;
  logic [DW-1:0] dm_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    output ext_gnt, ext_rvalid, ext_rdata,
    output dm_we, dm_addr, dm_din, dm_dmtype,
    input  dm_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  dm_we, dm_addr, dm_din, dm_dmtype,
    output dm_dout
  );
endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin pick between CPU and external requester.
// Optional burst lock (macro DM_ARB_BURST_EN): a locked external grant
// starts a burst in which ext wins ties for up to MAX_BURST grants.
module rr_arb2
  import dm_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req_i,
  input  logic ext_req_i,
  input  logic ext_lock_i,
  output logic cpu_gnt_o,
  output logic ext_gnt_o,
  output req_e last_grant_o
);

  req_e last_grant_q, last_grant_d;
  logic ext_wins_tie;

`ifdef DM_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          burst_hold;
`else
  localparam int unused_max_burst = MAX_BURST;
  logic unused_lock;
  assign unused_lock = ext_lock_i;
`endif

  assign last_grant_o = last_grant_q;

  // Arbitration state: last winner and burst length.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= REQ_EXT;
`ifdef DM_ARB_BURST_EN
      burst_cnt_q  <= '0;
`endif
    end else begin
      last_grant_q <= last_grant_d;
`ifdef DM_ARB_BURST_EN
      burst_cnt_q  <= burst_cnt_d;
`endif
    end
  end

  // Grant selection and next-state; nothing is granted during reset.
  always_comb begin
    cpu_gnt_o    = 1'b0;
    ext_gnt_o    = 1'b0;
    last_grant_d = last_grant_q;
`ifdef DM_ARB_BURST_EN
    burst_cnt_d  = '0;
    // Burst in progress, limit not yet reached, lock still held.
    burst_hold   = (burst_cnt_q != '0) && (burst_cnt_q < CW'(MAX_BURST)) &&
                   ext_req_i && ext_lock_i;
    ext_wins_tie = burst_hold || (last_grant_q == REQ_CPU);
`else
    ext_wins_tie = (last_grant_q == REQ_CPU);
`endif
    if (!reset) begin
      if (cpu_req_i && ext_req_i) begin
        ext_gnt_o = ext_wins_tie;
        cpu_gnt_o = !ext_wins_tie;
      end else begin
        cpu_gnt_o = cpu_req_i;
        ext_gnt_o = ext_req_i;
      end
    end
    if (cpu_gnt_o) begin
      last_grant_d = REQ_CPU;
    end else if (ext_gnt_o) begin
      last_grant_d = REQ_EXT;
    end
`ifdef DM_ARB_BURST_EN
    // A locked ext grant extends the burst; hitting the limit restarts at 1.
    // Any other cycle (lock or req low, CPU grant) clears the count.
    if (ext_gnt_o && ext_lock_i) begin
      burst_cnt_d = (burst_cnt_q >= CW'(MAX_BURST)) ? CW'(1) : burst_cnt_q + 1'b1;
    end
`endif
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the
// CPU MEM stage and an external loader/DMA port, one access per cycle,
// with a registered one-cycle read response and a CPU stall.
// Optional feature macro: DM_ARB_BURST_EN (external burst lock).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic     clk,
  input  logic     reset,
  dm_arb_if.slave  bus,
  output req_e     dbg_last_grant_o
);

  logic          cpu_gnt, ext_gnt;
  logic          cpu_rvalid_q, ext_rvalid_q;
  logic [DW-1:0] cpu_rdata_q, ext_rdata_q;

  rr_arb2 #(.MAX_BURST(MAX_BURST)) u_rr (
    .clk          (clk),
    .reset        (reset),
    .cpu_req_i    (bus.cpu_req),
    .ext_req_i    (bus.ext_req),
    .ext_lock_i   (bus.ext_lock),
    .cpu_gnt_o    (cpu_gnt),
    .ext_gnt_o    (ext_gnt),
    .last_grant_o (dbg_last_grant_o)
  );

  // Memory port follows the winner; idle cycles present the CPU fields.
  always_comb begin
    bus.dm_we     = (cpu_gnt && bus.cpu_we) || (ext_gnt && bus.ext_we);
    bus.dm_addr   = ext_gnt ? bus.ext_addr  : bus.cpu_addr;
    bus.dm_din    = ext_gnt ? bus.ext_wdata : bus.cpu_wdata;
    bus.dm_dmtype = ext_gnt ? DMT_WORD      : bus.cpu_dmtype;
  end

  // Capture read data at the end of the issue cycle for the winning port.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_gnt && !bus.cpu_we;
      ext_rvalid_q <= ext_gnt && !bus.ext_we;
      if (cpu_gnt && !bus.cpu_we) cpu_rdata_q <= bus.dm_dout;
      if (ext_gnt && !bus.ext_we) ext_rdata_q <= bus.dm_dout;
    end
  end

  // Port-side outputs; a response pending when reset arrives is dropped.
  always_comb begin
    bus.cpu_gnt    = cpu_gnt;
    bus.ext_gnt    = ext_gnt;
    bus.cpu_stall  = bus.cpu_req && !cpu_gnt;
    bus.cpu_rvalid = cpu_rvalid_q && !reset;
    bus.ext_rvalid = ext_rvalid_q && !reset;
    bus.cpu_rdata  = cpu_rdata_q;
    bus.ext_rdata  = ext_rdata_q;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter with a small data-memory model.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam logic [1:0] G_CPU = 2'b01;  // {ext_gnt, cpu_gnt}
  localparam logic [1:0] G_EXT = 2'b10;

  logic  clk;
  logic  reset;
  req_e  dbg_last;
  int    n_checks;
  int    n_fail;
  logic [31:0] mem [0:255];
  logic [1:0]  exp_q[$];

  dm_arb_if #(.AW(30), .DW(32)) bus ();

  dm_arbiter #(.AW(30), .DW(32), .MAX_BURST(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .dbg_last_grant_o (dbg_last)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Data memory model: combinational read, clocked write.
  assign bus.dm_dout = mem[bus.dm_addr[7:0]];
  always @(posedge clk) begin
    if (bus.dm_we) mem[bus.dm_addr[7:0]] <= bus.dm_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [29:0] addr,
                           input logic [31:0] wdata, input logic [2:0] dmt);
    bus.cpu_req    = req;
    bus.cpu_we     = we;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wdata;
    bus.cpu_dmtype = dmt;
  endtask

  task automatic ext_drive(input logic req, input logic we, input logic lock,
                           input logic [29:0] addr, input logic [31:0] wdata);
    bus.ext_req   = req;
    bus.ext_we    = we;
    bus.ext_lock  = lock;
    bus.ext_addr  = addr;
    bus.ext_wdata = wdata;
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] prev;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'h0BADC0DE;
    reset = 1'b1;
    cpu_drive(1'b0, 1'b0, 30'h0, 32'h0, 3'b000);
    ext_drive(1'b0, 1'b0, 1'b0, 30'h0, 32'h0);

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check("rst_ext_gnt", 32'(bus.ext_gnt), 32'd0);
    check("rst_dm_we", 32'(bus.dm_we), 32'd0);
    check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("rst_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_ext_rdata", bus.ext_rdata, 32'h0);
    check("rst_last_grant", 32'(dbg_last), 32'(REQ_EXT));

    // CPU read of 0x10
    tick();
    reset = 1'b0;
    cpu_drive(1'b1, 1'b0, 30'h10, 32'h0, 3'b010);
    @(negedge clk);
    check("rd_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("rd_ext_gnt", 32'(bus.ext_gnt), 32'd0);
    check("rd_stall", 32'(bus.cpu_stall), 32'd0);
    check("rd_dm_addr", 32'(bus.dm_addr), 32'h10);
    check("rd_dm_dmtype", 32'(bus.dm_dmtype), 32'h2);
    check("rd_dm_we", 32'(bus.dm_we), 32'd0);
    tick();
    cpu_drive(1'b0, 1'b0, 30'h10, 32'h0, 3'b010);
    @(negedge clk);
    check("rd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("rd_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check("rd_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
    tick();
    @(negedge clk);
    check("rd_rvalid_once", 32'(bus.cpu_rvalid), 32'd0);
    check("rd_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);

    // External write of 0x12345678 to 0x20, then CPU reads it back
    tick();
    ext_drive(1'b1, 1'b1, 1'b0, 30'h20, 32'h12345678);
    @(negedge clk);
    check("wr_ext_gnt", 32'(bus.ext_gnt), 32'd1);
    check("wr_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check("wr_dm_we", 32'(bus.dm_we), 32'd1);
    check("wr_dm_dmtype", 32'(bus.dm_dmtype), 32'h0);
    check("wr_dm_addr", 32'(bus.dm_addr), 32'h20);
    check("wr_dm_din", bus.dm_din, 32'h12345678);
    tick();
    ext_drive(1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    cpu_drive(1'b1, 1'b0, 30'h20, 32'h0, 3'b000);
    @(negedge clk);
    check("wr_rb_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("wr_no_rvalid", 32'(bus.ext_rvalid), 32'd0);
    tick();
    cpu_drive(1'b0, 1'b0, 30'h20, 32'h0, 3'b000);
    @(negedge clk);
    check("wr_rb_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("wr_rb_rdata", bus.cpu_rdata, 32'h12345678);

    // Reset in the cycle after a read grant, with a write presented
    tick();
    cpu_drive(1'b1, 1'b0, 30'h10, 32'h0, 3'b000);
    @(negedge clk);
    check("mr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    tick();
    reset = 1'b1;
    cpu_drive(1'b0, 1'b0, 30'h10, 32'h0, 3'b000);
    ext_drive(1'b1, 1'b1, 1'b0, 30'h30, 32'hCAFEF00D);
    @(negedge clk);
    check("mr_rvalid_drop", 32'(bus.cpu_rvalid), 32'd0);
    check("mr_dm_we", 32'(bus.dm_we), 32'd0);
    check("mr_ext_gnt", 32'(bus.ext_gnt), 32'd0);
    tick();
    reset = 1'b0;
    ext_drive(1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    cpu_drive(1'b1, 1'b0, 30'h30, 32'h0, 3'b000);
    @(negedge clk);
    check("mr_post_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("mr_post_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    tick();
    cpu_drive(1'b0, 1'b0, 30'h0, 32'h0, 3'b000);
    @(negedge clk);
    check("mr_mem_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("mr_mem_unchanged", bus.cpu_rdata, 32'h0BADC0DE);

    // Round robin from reset: both read continuously
    tick();
    reset = 1'b1;
    exp_q = {G_CPU, G_EXT, G_CPU, G_EXT, G_CPU, G_EXT};
    prev = 2'b00;
    for (int k = 0; k < 6; k++) begin
      tick();
      reset = 1'b0;
      cpu_drive(1'b1, 1'b0, 30'h10, 32'h0, 3'b000);
      ext_drive(1'b1, 1'b0, 1'b0, 30'h20, 32'h0);
      @(negedge clk);
      g = exp_q.pop_front();
      check($sformatf("rr_gnt_%0d", k), 32'({bus.ext_gnt, bus.cpu_gnt}), 32'(g));
      check($sformatf("rr_stall_%0d", k), 32'(bus.cpu_stall), 32'(g[1]));
      check($sformatf("rr_cpu_rvalid_%0d", k), 32'(bus.cpu_rvalid), 32'(prev == G_CPU));
      check($sformatf("rr_ext_rvalid_%0d", k), 32'(bus.ext_rvalid), 32'(prev == G_EXT));
      if (prev == G_CPU) check($sformatf("rr_cpu_rdata_%0d", k), bus.cpu_rdata, 32'hDEADBEEF);
      if (prev == G_EXT) check($sformatf("rr_ext_rdata_%0d", k), bus.ext_rdata, 32'h12345678);
      prev = g;
    end

    // Both requesting with ext_lock held
    tick();
    reset = 1'b1;
    cpu_drive(1'b0, 1'b0, 30'h0, 32'h0, 3'b000);
    ext_drive(1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
`ifdef DM_ARB_BURST_EN
    exp_q = {G_CPU, G_EXT, G_EXT, G_EXT, G_EXT, G_CPU,
             G_EXT, G_EXT, G_EXT, G_EXT, G_CPU};
`else
    exp_q = {G_CPU, G_EXT, G_CPU, G_EXT, G_CPU, G_EXT,
             G_CPU, G_EXT, G_CPU, G_EXT, G_CPU};
`endif
    for (int k = 0; k < 11; k++) begin
      tick();
      reset = 1'b0;
      cpu_drive(1'b1, 1'b0, 30'h10, 32'h0, 3'b000);
      ext_drive(1'b1, 1'b0, 1'b1, 30'h20, 32'h0);
      @(negedge clk);
      g = exp_q.pop_front();
      check($sformatf("lock_gnt_%0d", k), 32'({bus.ext_gnt, bus.cpu_gnt}), 32'(g));
    end

    // Last grant was CPU: a tie now goes to ext, then the CPU withdraws
    tick();
    cpu_drive(1'b1, 1'b0, 30'h10, 32'h0, 3'b000);
    ext_drive(1'b1, 1'b0, 1'b0, 30'h20, 32'h0);
    @(negedge clk);
    check("drop_ext_gnt", 32'(bus.ext_gnt), 32'd1);
    check("drop_stall", 32'(bus.cpu_stall), 32'd1);
    tick();
    cpu_drive(1'b0, 1'b1, 30'h55, 32'hA5A5A5A5, 3'b001);
    ext_drive(1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    @(negedge clk);
    check("idle_gnts", 32'({bus.ext_gnt, bus.cpu_gnt}), 32'd0);
    check("idle_dm_we", 32'(bus.dm_we), 32'd0);
    check("idle_dm_addr", 32'(bus.dm_addr), 32'h55);
    check("idle_dm_din", bus.dm_din, 32'hA5A5A5A5);
    check("idle_dm_dmtype", 32'(bus.dm_dmtype), 32'h1);
    check("idle_stall", 32'(bus.cpu_stall), 32'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
